// File: rtl/rx_pkt_capture_ctrl_if.sv
// Sample stream into the capture controller and valid/ready word stream out to the DMA.
interface rx_pkt_capture_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0]   i_in_i;
    logic [DATA_W-1:0]   i_in_q;
    logic                i_in_vld;
    logic                i_sop;
    logic [2*DATA_W-1:0] o_dma_data;
    logic                o_dma_vld;
    logic                i_dma_rdy;
    logic                o_dma_last;

    // master: the capture controller; slave: sample source plus DMA sink
    modport master (
        input  i_in_i, i_in_q, i_in_vld, i_sop, i_dma_rdy,
        output o_dma_data, o_dma_vld, o_dma_last
    );

    modport slave (
        output i_in_i, i_in_q, i_in_vld, i_sop, i_dma_rdy,
        input  o_dma_data, o_dma_vld, o_dma_last
    );
endinterface

// File: rtl/rx_pkt_capture_ctrl.sv
// Captures PKT_LEN samples after a frame-sync pulse, then drains them as one burst.
// Last write -> first o_dma_vld on the 2nd DRAIN cycle; DMA stalls are absorbed by a 2-entry skid.
module rx_pkt_capture_ctrl #(
    parameter int DATA_W  = 16,
    parameter int PKT_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_arm,
    input  logic                  i_auto_rearm,
    rx_pkt_capture_ctrl_if.master bus,
    output logic [1:0]            o_state,
    output logic [CNT_W-1:0]      o_pkt_cnt,
    output logic [CNT_W-1:0]      o_drop_cnt
);
    localparam int            AW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int            WORD_W    = 2 * DATA_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOP = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   mem [PKT_LEN];
    logic [AW-1:0]       wptr, rptr, wr_addr;
    logic                rd_done;
    logic                wr_en, rd_en, drop_inc;
    logic                sop_vld, xfer, last_xfer;
    logic [WORD_W-1:0]   rd_dat;
    logic                rd_last;
    logic [WORD_W-1:0]   sk_dat;
    logic                sk_last, sk_vld;

    assign sop_vld   = bus.i_in_vld & bus.i_sop;
    assign xfer      = bus.o_dma_vld & bus.i_dma_rdy;
    assign last_xfer = xfer & bus.o_dma_last;
    assign rd_dat    = mem[rptr];
    assign rd_last   = (rptr == LAST_ADDR);
    assign o_state   = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = wptr;
        rd_en     = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_arm) state_nxt = ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
                if (sop_vld) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A sync pulse mid-packet is stored as data but never re-aligns the capture
                drop_inc = sop_vld;
                if (bus.i_in_vld) begin
                    wr_en = 1'b1;
                    if (wptr == LAST_ADDR) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drop_inc = sop_vld;
                // Fetch only while the skid has a free slot, so no read is ever lost
                rd_en    = !rd_done && !sk_vld;
                if (last_xfer) state_nxt = i_auto_rearm ? ST_WAIT_SOP : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!i_en) begin
            state_nxt = ST_IDLE;
            wr_en     = 1'b0;
            rd_en     = 1'b0;
            drop_inc  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr] <= {bus.i_in_q, bus.i_in_i};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr           <= '0;
            rptr           <= '0;
            rd_done        <= 1'b0;
            sk_dat         <= '0;
            sk_last        <= 1'b0;
            sk_vld         <= 1'b0;
            bus.o_dma_data <= '0;
            bus.o_dma_last <= 1'b0;
            bus.o_dma_vld  <= 1'b0;
            o_pkt_cnt      <= '0;
            o_drop_cnt     <= '0;
        end else begin
            if (wr_en)      wptr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + AW'(1);
            else if (!i_en) wptr <= '0;

            if (state != ST_DRAIN || !i_en) begin
                rptr    <= '0;
                rd_done <= 1'b0;
            end else if (rd_en) begin
                rptr    <= rd_last ? '0 : rptr + AW'(1);
                rd_done <= rd_last;
            end

            // Output register is the skid head; the spare slot refills it after a stall
            if (!i_en) begin
                bus.o_dma_vld <= 1'b0;
                sk_vld        <= 1'b0;
            end else if (!bus.o_dma_vld || xfer) begin
                if (sk_vld) begin
                    bus.o_dma_data <= sk_dat;
                    bus.o_dma_last <= sk_last;
                    bus.o_dma_vld  <= 1'b1;
                    sk_vld         <= 1'b0;
                end else if (rd_en) begin
                    bus.o_dma_data <= rd_dat;
                    bus.o_dma_last <= rd_last;
                    bus.o_dma_vld  <= 1'b1;
                end else begin
                    bus.o_dma_vld  <= 1'b0;
                end
            end else if (rd_en) begin
                sk_dat  <= rd_dat;
                sk_last <= rd_last;
                sk_vld  <= 1'b1;
            end

            if (last_xfer && i_en) o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
            if (drop_inc && (o_drop_cnt != {CNT_W{1'b1}})) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rx_pkt_capture_ctrl.sv
// Directed scenario sequence with random sample data, checked against a packet-level queue model.
module tb_rx_pkt_capture_ctrl;
    localparam int DW    = 16;
    localparam int PLEN  = 8;
    localparam int CW    = 4;
    localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst, en, arm, rearm;
    logic [1:0]    st;
    logic [CW-1:0] pkt_cnt, drop_cnt;
    int            total = 0, bad = 0;
    int            rdy_mode = 0;
    bit            mon_on = 1'b0;

    rx_pkt_capture_ctrl_if #(.DATA_W(DW)) bus_if ();

    rx_pkt_capture_ctrl #(.DATA_W(DW), .PKT_LEN(PLEN), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_arm(arm), .i_auto_rearm(rearm),
        .bus(bus_if), .o_state(st), .o_pkt_cnt(pkt_cnt), .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: spec-level phases, captured words as a queue, plain integer counters
    int          ph = M_IDLE, exp_pkt = 0, exp_drop = 0, drain_cyc = 0;
    logic [31:0] cap_q[$], exp_q[$], got_q[$];
    bit          rdy_all = 1'b1, post_rst = 1'b1, hold = 1'b0;
    logic [31:0] prev_dat;
    logic        prev_last;

    always @(negedge clk) begin
        if (mon_on) begin
            logic [31:0] smp;
            smp = {bus_if.i_in_q, bus_if.i_in_i};
            chk("state", st, ph);
            chk("pkt_cnt", pkt_cnt, exp_pkt);
            chk("drop_cnt", drop_cnt, exp_drop);
            if (ph != M_DRAIN) chk("vld_outside_drain", bus_if.o_dma_vld, 0);
            if (post_rst) begin
                chk("rst_data", bus_if.o_dma_data, 0);
                chk("rst_last", bus_if.o_dma_last, 0);
            end
            if (hold) begin
                chk("stall_vld", bus_if.o_dma_vld, 1);
                chk("stall_data", bus_if.o_dma_data, prev_dat);
                chk("stall_last", bus_if.o_dma_last, prev_last);
            end
            if (ph == M_DRAIN) begin
                if (drain_cyc == 0)      chk("drain_c0_vld", bus_if.o_dma_vld, 0);
                else if (drain_cyc == 1) chk("drain_c1_vld", bus_if.o_dma_vld, 1);
                else if (rdy_all && exp_q.size() > 0) chk("no_bubble", bus_if.o_dma_vld, 1);
                if (bus_if.o_dma_vld) begin
                    if (exp_q.size() == 0) chk("extra_word", bus_if.o_dma_vld, 0);
                    else begin
                        chk("dma_data", bus_if.o_dma_data, exp_q[0]);
                        chk("dma_last", bus_if.o_dma_last, exp_q.size() == 1);
                    end
                end
            end
            hold      = bus_if.o_dma_vld && !bus_if.i_dma_rdy && !rst && en;
            prev_dat  = bus_if.o_dma_data;
            prev_last = bus_if.o_dma_last;
            post_rst  = rst;
            if (rst) begin
                ph = M_IDLE; exp_pkt = 0; exp_drop = 0;
                cap_q.delete(); exp_q.delete();
            end else if (!en) begin
                ph = M_IDLE; cap_q.delete(); exp_q.delete();
            end else begin
                case (ph)
                    M_IDLE: if (arm) ph = M_WAIT;
                    M_WAIT: if (bus_if.i_in_vld && bus_if.i_sop) begin
                        cap_q.delete(); cap_q.push_back(smp); ph = M_CAP;
                    end
                    M_CAP: if (bus_if.i_in_vld) begin
                        cap_q.push_back(smp);
                        if (bus_if.i_sop && exp_drop < (1 << CW) - 1) exp_drop++;
                        if (cap_q.size() == PLEN) begin
                            exp_q = cap_q; cap_q.delete();
                            ph = M_DRAIN; drain_cyc = 0; rdy_all = 1'b1;
                        end
                    end
                    default: begin
                        if (bus_if.i_in_vld && bus_if.i_sop && exp_drop < (1 << CW) - 1) exp_drop++;
                        if (bus_if.o_dma_vld && !bus_if.i_dma_rdy) rdy_all = 1'b0;
                        drain_cyc++;
                        if (bus_if.o_dma_vld && bus_if.i_dma_rdy && exp_q.size() > 0) begin
                            got_q.push_back(bus_if.o_dma_data);
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) begin
                                exp_pkt = (exp_pkt + 1) % (1 << CW);
                                ph = rearm ? M_WAIT : M_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_mode == 1)      bus_if.i_dma_rdy = 1'($urandom_range(0, 1));
        else if (rdy_mode == 2) bus_if.i_dma_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n = 0;
        while (st !== s && n < 200) begin tick(); n++; end
        chk(tag, st, s);
    endtask

    // One full packet: sop sample then PLEN-1 further samples, random gaps; extra_sop[k] marks sample k
    task automatic feed_pkt(input logic [7:0] extra_sop);
        int k = 0;
        while (k < PLEN) begin
            if (k > 0 && $urandom_range(0, 3) == 0) begin
                bus_if.i_in_vld = 1'b0;
                bus_if.i_sop    = 1'($urandom_range(0, 1));
            end else begin
                bus_if.i_in_vld = 1'b1;
                bus_if.i_sop    = (k == 0) ? 1'b1 : extra_sop[k];
                bus_if.i_in_i   = DW'($urandom);
                bus_if.i_in_q   = DW'($urandom);
                k++;
            end
            tick();
        end
        bus_if.i_in_vld = 1'b0;
        bus_if.i_sop    = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; arm = 1'b0; rearm = 1'b0;
        bus_if.i_in_i = '0; bus_if.i_in_q = '0; bus_if.i_in_vld = 1'b0;
        bus_if.i_sop = 1'b0; bus_if.i_dma_rdy = 1'b1;
        tick(); tick();
        chk("rst_state", st, 0);
        chk("rst_vld", bus_if.o_dma_vld, 0);
        chk("rst_last0", bus_if.o_dma_last, 0);
        chk("rst_data0", bus_if.o_dma_data, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        mon_on = 1'b1; rst = 1'b0; en = 1'b1;

        // T1: ramp samples, sync on value 5
        got_q.delete();
        arm = 1'b1; tick(); arm = 1'b0;
        for (int v = 0; v <= 12; v++) begin
            bus_if.i_in_vld = 1'b1; bus_if.i_sop = (v == 5);
            bus_if.i_in_i = DW'(v); bus_if.i_in_q = DW'($urandom);
            tick();
        end
        bus_if.i_in_vld = 1'b0; bus_if.i_sop = 1'b0;
        wait_state(2'd0, "t1_idle");
        chk("t1_pkt", pkt_cnt, 1);
        chk("t1_words", got_q.size(), PLEN);
        for (int k = 0; k < PLEN && k < got_q.size(); k++)
            chk("t1_word_i", got_q[k][15:0], 5 + k);

        // T2: sync pulse without valid is ignored; T3: random DMA stalls
        arm = 1'b1; tick(); arm = 1'b0;
        bus_if.i_sop = 1'b1;
        repeat (3) tick();
        bus_if.i_sop = 1'b0;
        chk("t2_wait", st, 1);
        chk("t2_drop", drop_cnt, 0);
        got_q.delete();
        rdy_mode = 1;
        feed_pkt(8'h00);
        wait_state(2'd0, "t3_idle");
        rdy_mode = 0; bus_if.i_dma_rdy = 1'b1;
        chk("t3_words", got_q.size(), PLEN);
        chk("t3_pkt", pkt_cnt, 2);

        // T4: auto re-arm, two drops in capture and one in drain
        rearm = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        feed_pkt(8'b0010_0100);
        tick();
        bus_if.i_in_vld = 1'b1; bus_if.i_sop = 1'b1; tick();
        bus_if.i_in_vld = 1'b0; bus_if.i_sop = 1'b0;
        wait_state(2'd1, "t4_rearmed");
        chk("t4_drop", drop_cnt, 3);
        rearm = 1'b0;
        feed_pkt(8'h00);
        wait_state(2'd0, "t4_idle");
        chk("t4_pkt", pkt_cnt, 4);

        // T5: disable mid-capture, then a fresh packet
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_if.i_in_vld = 1'b1; bus_if.i_sop = (k == 0);
            bus_if.i_in_i = DW'($urandom); bus_if.i_in_q = DW'($urandom);
            if (k == 4) en = 1'b0;
            tick();
        end
        bus_if.i_in_vld = 1'b0; bus_if.i_sop = 1'b0;
        chk("t5_state", st, 0);
        chk("t5_vld", bus_if.o_dma_vld, 0);
        chk("t5_pkt_held", pkt_cnt, 4);
        en = 1'b1; arm = 1'b1; tick(); arm = 1'b0;
        feed_pkt(8'h00);
        wait_state(2'd0, "t5_idle");
        chk("t5_pkt", pkt_cnt, 5);

        // T6: reset while a word is stalled on the DMA port
        bus_if.i_dma_rdy = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        feed_pkt(8'h00);
        for (int n = 0; n < 10 && !bus_if.o_dma_vld; n++) tick();
        chk("t6_vld_before", bus_if.o_dma_vld, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        bus_if.i_dma_rdy = 1'b1;
        chk("t6_state", st, 0);
        chk("t6_vld", bus_if.o_dma_vld, 0);
        chk("t6_last", bus_if.o_dma_last, 0);
        chk("t6_data", bus_if.o_dma_data, 0);
        chk("t6_pkt", pkt_cnt, 0);
        chk("t6_drop", drop_cnt, 0);

        // T7: counter boundaries -- packet count wraps, drop count saturates
        rearm = 1'b1; rdy_mode = 2;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int p = 0; p < 16; p++) begin
            wait_state(2'd1, "t7_wait");
            if (p == 15) chk("t7_pkt15", pkt_cnt, 15);
            feed_pkt(8'b0000_0100);
        end
        wait_state(2'd1, "t7_final");
        rdy_mode = 0;
        chk("t7_pkt_wrap", pkt_cnt, 0);
        chk("t7_drop_sat", drop_cnt, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
